// File: rtl/character_position_bank_pkg.sv
// Shared types and constants for the character position bank.
package character_position_bank_pkg;

  // Move direction encoding.
  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_e;

  // Frame FSM states; StCheck is only reachable with collision detection built in.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCopy  = 2'd1,
    StCheck = 2'd2
  } state_e;

  // Reset spawn layout: pacman fixed, ghosts spaced along one row.
  localparam logic [7:0] PacSpawnX      = 8'd50;
  localparam logic [7:0] PacSpawnY      = 8'd60;
  localparam int         GhostSpawnX0   = 40;
  localparam int         GhostSpawnStep = 10;
  localparam logic [7:0] GhostSpawnY    = 8'd40;

  // Sprites are square; two sprites overlap when both axis distances are below this.
  localparam logic [7:0] SpriteSize = 8'd5;

  function automatic logic [7:0] spawn_x(input int idx);
    return (idx == 0) ? PacSpawnX : 8'(GhostSpawnX0 + GhostSpawnStep * (idx - 1));
  endfunction

  function automatic logic [7:0] spawn_y(input int idx);
    return (idx == 0) ? PacSpawnY : GhostSpawnY;
  endfunction

endpackage

// File: rtl/char_step_unit.sv
// One-step position update for a single character: y saturates, x wraps.
module char_step_unit
  import character_position_bank_pkg::*;
#(
  parameter logic [7:0] MAX_X = 8'd100,
  parameter logic [7:0] MAX_Y = 8'd100
) (
  input  logic [7:0] cur_x,
  input  logic [7:0] cur_y,
  input  logic [1:0] dir,
  output logic [7:0] next_x,
  output logic [7:0] next_y
);

  // Apply exactly one direction step to the current position.
  always_comb begin
    next_x = cur_x;
    next_y = cur_y;
    case (dir)
      DirUp:    next_y = (cur_y == 8'd0) ? 8'd0 : cur_y - 8'd1;
      DirDown:  next_y = (cur_y >= MAX_Y) ? MAX_Y : cur_y + 8'd1;
      DirLeft:  next_x = (cur_x == 8'd0) ? MAX_X : cur_x - 8'd1;
      DirRight: next_x = (cur_x >= MAX_X) ? 8'd0 : cur_x + 8'd1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/character_position_bank.sv
// Double-buffered character position store: moves update the working bank, a frame tick
// snapshots it into the display bank one character per cycle. Optional pacman/ghost
// overlap check is enabled by defining COLLISION_DETECT_EN.
module character_position_bank
  import character_position_bank_pkg::*;
#(
  parameter int         NUM_CHARS = 4,
  parameter logic [7:0] MAX_X     = 8'd100,
  parameter logic [7:0] MAX_Y     = 8'd100
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic [2:0] character_type,
  output logic [7:0] char_x,
  output logic [7:0] char_y,
  output logic       pacman_orientation,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [2:0] move_char,
  input  logic [1:0] move_dir,
  input  logic       frame_tick,
  output logic       copy_done,
  output logic       frame_overrun,
  output logic       collision,
  output logic [2:0] collision_ghost
);

  localparam logic [2:0] LastIdx = 3'(NUM_CHARS - 1);

  logic [7:0] work_x [NUM_CHARS];
  logic [7:0] work_y [NUM_CHARS];
  logic [7:0] disp_x [NUM_CHARS];
  logic [7:0] disp_y [NUM_CHARS];
  logic       work_orient;
  logic       disp_orient;

  state_e     state;
  logic [2:0] copy_idx;

  logic       move_fire;
  logic       sel_hit;
  logic [7:0] sel_x, sel_y;
  logic [7:0] step_x, step_y;

  assign move_ready = reset_n && (state == StIdle);
  assign move_fire  = move_valid && move_ready;

  // Select the working-bank entry addressed by the move; out-of-range indices select nothing.
  always_comb begin
    sel_hit = 1'b0;
    sel_x   = 8'd0;
    sel_y   = 8'd0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (move_char == 3'(i)) begin
        sel_hit = 1'b1;
        sel_x   = work_x[i];
        sel_y   = work_y[i];
      end
    end
  end

  char_step_unit #(
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_step (
    .cur_x  (sel_x),
    .cur_y  (sel_y),
    .dir    (move_dir),
    .next_x (step_x),
    .next_y (step_y)
  );

  // Display-side read port: display bank only, out-of-range reads as origin.
  always_comb begin
    char_x = 8'd0;
    char_y = 8'd0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (character_type == 3'(i)) begin
        char_x = disp_x[i];
        char_y = disp_y[i];
      end
    end
  end

  assign pacman_orientation = disp_orient;

  // Bank storage: moves write the working bank, COPY writes one display entry per cycle.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        work_x[i] <= spawn_x(i);
        work_y[i] <= spawn_y(i);
        disp_x[i] <= spawn_x(i);
        disp_y[i] <= spawn_y(i);
      end
      work_orient <= 1'b0;
      disp_orient <= 1'b0;
    end else begin
      if (move_fire && sel_hit) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
          if (move_char == 3'(i)) begin
            work_x[i] <= step_x;
            work_y[i] <= step_y;
          end
        end
        if (move_char == 3'd0) begin
          if (move_dir == DirLeft) work_orient <= 1'b0;
          else if (move_dir == DirRight) work_orient <= 1'b1;
        end
      end
      if (state == StCopy) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
          if (copy_idx == 3'(i)) begin
            disp_x[i] <= work_x[i];
            disp_y[i] <= work_y[i];
          end
        end
        if (copy_idx == 3'd0) disp_orient <= work_orient;
      end
    end
  end

`ifdef COLLISION_DETECT_EN
  logic [2:0] chk_idx;
  logic [7:0] ghost_x, ghost_y;
  logic [7:0] dist_x, dist_y;
  logic       overlap;

  // Distance between pacman and the ghost currently being checked, in the display bank.
  always_comb begin
    ghost_x = 8'd0;
    ghost_y = 8'd0;
    for (int i = 1; i < NUM_CHARS; i++) begin
      if (chk_idx == 3'(i)) begin
        ghost_x = disp_x[i];
        ghost_y = disp_y[i];
      end
    end
    dist_x  = (disp_x[0] >= ghost_x) ? disp_x[0] - ghost_x : ghost_x - disp_x[0];
    dist_y  = (disp_y[0] >= ghost_y) ? disp_y[0] - ghost_y : ghost_y - disp_y[0];
    overlap = (dist_x < SpriteSize) && (dist_y < SpriteSize);
  end
`else
  assign collision       = 1'b0;
  assign collision_ghost = 3'd0;
`endif

  // Frame FSM with registered pulse/sticky outputs.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= StIdle;
      copy_idx      <= 3'd0;
      copy_done     <= 1'b0;
      frame_overrun <= 1'b0;
`ifdef COLLISION_DETECT_EN
      chk_idx         <= 3'd1;
      collision       <= 1'b0;
      collision_ghost <= 3'd0;
`endif
    end else begin
      copy_done <= 1'b0;
`ifdef COLLISION_DETECT_EN
      collision <= 1'b0;
`endif
      if (frame_tick && (state != StIdle)) frame_overrun <= 1'b1;
      case (state)
        StIdle: begin
          if (frame_tick) begin
            state    <= StCopy;
            copy_idx <= 3'd0;
          end
        end
        StCopy: begin
          if (copy_idx == LastIdx) begin
            copy_done <= 1'b1;
`ifdef COLLISION_DETECT_EN
            state   <= (NUM_CHARS > 1) ? StCheck : StIdle;
            chk_idx <= 3'd1;
`else
            state   <= StIdle;
`endif
          end else begin
            copy_idx <= copy_idx + 3'd1;
          end
        end
`ifdef COLLISION_DETECT_EN
        StCheck: begin
          if (overlap) begin
            collision       <= 1'b1;
            collision_ghost <= chk_idx;
            state           <= StIdle;
          end else if (chk_idx == LastIdx) begin
            state <= StIdle;
          end else begin
            chk_idx <= chk_idx + 3'd1;
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_character_position_bank.sv
// Bench for character_position_bank: frame-level reference model plus directed scenarios.
module tb_character_position_bank;

  localparam int NumChars = 4;
  localparam int MaxPos   = 100;

  logic       clk;
  logic       rst_n;
  logic [2:0] character_type;
  logic [7:0] char_x, char_y;
  logic       pacman_orientation;
  logic       move_valid, move_ready;
  logic [2:0] move_char;
  logic [1:0] move_dir;
  logic       frame_tick, copy_done, frame_overrun, collision;
  logic [2:0] collision_ghost;

  int n_vec = 0;
  int n_err = 0;

  character_position_bank dut (
    .clock_50           (clk),
    .reset_n            (rst_n),
    .character_type     (character_type),
    .char_x             (char_x),
    .char_y             (char_y),
    .pacman_orientation (pacman_orientation),
    .move_valid         (move_valid),
    .move_ready         (move_ready),
    .move_char          (move_char),
    .move_dir           (move_dir),
    .frame_tick         (frame_tick),
    .copy_done          (copy_done),
    .frame_overrun      (frame_overrun),
    .collision          (collision),
    .collision_ghost    (collision_ghost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: working/display positions and the remaining length of the frame job.
  int mwx [NumChars], mwy [NumChars], mdx [NumChars], mdy [NumChars];
  int snap_x [NumChars], snap_y [NumChars];
  bit mwo, mdo, snap_o;
  int copy_left, check_left, col_g, m_ghost;
  bit m_copy_done, m_coll, m_over;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    return (copy_left == 0) && (check_left == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NumChars; i++) begin
      mwx[i] = (i == 0) ? 50 : 40 + 10 * (i - 1);
      mwy[i] = (i == 0) ? 60 : 40;
      mdx[i] = mwx[i];
      mdy[i] = mwy[i];
    end
    mwo = 0; mdo = 0;
    copy_left = 0; check_left = 0; col_g = 0; m_ghost = 0;
    m_copy_done = 0; m_coll = 0; m_over = 0;
  endtask

  task automatic model_step();
    bit idle_before;
    int c;
    idle_before = m_idle();
    m_copy_done = 0;
    m_coll = 0;
    if (frame_tick && !idle_before) m_over = 1;
    c = int'(move_char);
    if (move_valid && idle_before && c < NumChars) begin
      case (int'(move_dir))
        0: if (mwy[c] > 0) mwy[c] = mwy[c] - 1;
        1: if (mwy[c] < MaxPos) mwy[c] = mwy[c] + 1;
        2: begin
          mwx[c] = (mwx[c] == 0) ? MaxPos : mwx[c] - 1;
          if (c == 0) mwo = 0;
        end
        default: begin
          mwx[c] = (mwx[c] == MaxPos) ? 0 : mwx[c] + 1;
          if (c == 0) mwo = 1;
        end
      endcase
    end
    if (copy_left > 0) begin
      copy_left--;
      if (copy_left == 0) begin
        mdx = snap_x; mdy = snap_y; mdo = snap_o;
        m_copy_done = 1;
`ifdef COLLISION_DETECT_EN
        col_g = 0;
        for (int g = NumChars - 1; g >= 1; g--) begin
          int ax, ay;
          ax = (mdx[0] > mdx[g]) ? mdx[0] - mdx[g] : mdx[g] - mdx[0];
          ay = (mdy[0] > mdy[g]) ? mdy[0] - mdy[g] : mdy[g] - mdy[0];
          if (ax < 5 && ay < 5) col_g = g;
        end
        check_left = (col_g != 0) ? col_g : NumChars - 1;
`endif
      end
    end else if (check_left > 0) begin
      check_left--;
      if (check_left == 0 && col_g != 0) begin
        m_coll = 1;
        m_ghost = col_g;
      end
    end else if (idle_before && frame_tick) begin
      snap_x = mwx; snap_y = mwy; snap_o = mwo;
      copy_left = NumChars;
    end
  endtask

  initial begin
    forever begin
      if (rst_n !== 1'b1) model_reset();
      @(posedge clk or negedge rst_n);
      if (rst_n === 1'b1) model_step();
    end
  end

  // Per-cycle comparison against the model, sampled well after the rising edge.
  initial begin
    forever begin
      int ct, ex, ey;
      @(posedge clk);
      #4;
      check("move_ready", move_ready, (rst_n === 1'b1) && m_idle());
      check("copy_done", copy_done, m_copy_done);
      check("frame_overrun", frame_overrun, m_over);
      check("collision", collision, m_coll);
      check("collision_ghost", collision_ghost, m_ghost);
      if (m_idle()) begin
        ct = int'(character_type);
        ex = (ct < NumChars) ? mdx[ct] : 0;
        ey = (ct < NumChars) ? mdy[ct] : 0;
        check("char_x", char_x, ex);
        check("char_y", char_y, ey);
        check("pacman_orientation", pacman_orientation, mdo);
      end
    end
  end

  task automatic moves(input int ch, input int dir, input int n);
    @(negedge clk);
    move_valid = 1'b1;
    move_char  = ch[2:0];
    move_dir   = dir[1:0];
    repeat (n) @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(input int start, output int cnt);
    cnt = start;
    do begin
      @(posedge clk);
      #4;
      cnt++;
    end while (!copy_done && cnt < 40);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 check("ready_in_reset", move_ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #2 check("ready_after_reset", move_ready, 1);
  endtask

  task automatic read_pos(input int ct, input int ex, input int ey, input string name);
    @(negedge clk);
    character_type = ct[2:0];
    @(posedge clk);
    #4;
    check({name, "_x"}, char_x, ex);
    check({name, "_y"}, char_y, ey);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    character_type = 3'd0;
    move_valid = 1'b0;
    move_char = 3'd0;
    move_dir = 2'd0;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset then frame tick: latency and spawn snapshot.
    tick();
    wait_done(1, lat);
    check("copy_latency", lat, NumChars + 1);
    read_pos(0, 50, 60, "spawn_pac");
    check("spawn_orient", pacman_orientation, 0);
    read_pos(3, 60, 40, "spawn_ghost3");
    read_pos(6, 0, 0, "out_of_range_read");

    // Pacman wraps right to 0 facing right, then left wraps to MAX_X facing left.
    moves(0, 3, 51);
    moves(0, 2, 1);
    moves(5, 1, 3);
    tick();
    wait_done(1, lat);
    read_pos(0, 100, 60, "wrap_left");
    check("wrap_left_orient", pacman_orientation, 0);

    // Up saturates at 0.
    moves(0, 0, 70);
    tick();
    wait_done(1, lat);
    read_pos(0, 100, 0, "sat_up");

    // Ghost 2 down to MAX_Y and beyond.
    moves(2, 1, 63);
    tick();
    wait_done(1, lat);
    read_pos(2, 50, 100, "sat_down");

    // Tick and move in the same cycle: snapshot includes the move.
    do_reset();
    @(negedge clk);
    frame_tick = 1'b1;
    move_valid = 1'b1;
    move_char = 3'd0;
    move_dir = 2'd3;
    @(negedge clk);
    frame_tick = 1'b0;
    move_valid = 1'b0;
    @(posedge clk);
    #4 check("ready_in_copy", move_ready, 0);
    wait_done(2, lat);
    read_pos(0, 51, 60, "tick_with_move");
    check("tick_with_move_orient", pacman_orientation, 1);

    // Second tick during COPY: overrun latched, copy unaffected.
    tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #4;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_done(2, lat);
    check("overrun_copy_latency", lat, NumChars + 1);
    check("overrun_set", frame_overrun, 1);
    repeat (10) @(posedge clk);
    #4 check("overrun_held", frame_overrun, 1);

`ifdef COLLISION_DETECT_EN
    // Ghost 1 moved next to pacman collides.
    do_reset();
    moves(1, 3, 7);
    moves(1, 1, 18);
    tick();
    wait_done(1, lat);
    lat = 0;
    while (!collision && lat < 20) begin
      @(posedge clk);
      #4 lat++;
    end
    check("collision_seen", collision, 1);
    check("collision_ghost_1", collision_ghost, 1);

    // Reset in the middle of CHECK.
    do_reset();
    tick();
    wait_done(1, lat);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 check("reset_mid_check_collision", collision, 0);
    check("reset_mid_check_x", char_x, 50);
    check("reset_mid_check_y", char_y, 60);
    @(posedge clk);
    #2 rst_n = 1'b1;
    read_pos(1, 40, 40, "reset_mid_check_ghost1");
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
